// File: rtl/wt_load_ctrl.sv
// Weight loader: streams CONF_PE_ROW x K buffer words per kernel group into the PE
// matrix, one row at a time, then commits the group and waits for the matrix to ack.
module wt_load_ctrl #(
    parameter int CONF_PE_ROW       = 4,
    parameter int CONF_PE_COL       = 4,
    parameter int CONF_WT_BUF_DEPTH = 512,
    parameter int BIT_WIDTH         = 8,
    localparam int AW = $clog2(CONF_WT_BUF_DEPTH),
    localparam int DW = CONF_PE_COL * BIT_WIDTH,
    localparam int RW = (CONF_PE_ROW > 1) ? $clog2(CONF_PE_ROW) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   kernel_mode,
    input  logic [7:0]             group_num,
    input  logic [AW-1:0]          base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   wt_rd_en,
    output logic [AW-1:0]          wt_rd_addr,
    input  logic [DW-1:0]          wt_rd_data,
    output logic                   pe_wt_we,
    output logic [CONF_PE_ROW-1:0] pe_row_sel,
    output logic [4:0]             pe_wt_idx,
    output logic [2:0]             pe_wt_mode,
    output logic [DW-1:0]          pe_wt_data,
    output logic                   pe_wt_commit,
    input  logic                   pe_wt_ack
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_ACK, DONE} state_t;
    typedef enum logic [2:0] {
        A_MODE = 3'd0, B_MODE = 3'd1, C_MODE = 3'd2, D_MODE = 3'd3, E_MODE = 3'd4
    } PE_weight_mode_t;

    state_t                 state_q, state_d;
    logic                   mode5_q;
    logic [7:0]             gnum_q, grp_q;
    logic [AW-1:0]          addr_q;
    logic [4:0]             tap_q;
    logic [RW-1:0]          row_q;
    logic                   we_q, commit_q;
    logic [CONF_PE_ROW-1:0] row_sel_q;
    logic [4:0]             idx_q;
    logic [2:0]             wmode_q;

    logic tap_last, row_last, rd_fire;

    function automatic PE_weight_mode_t tap_mode(input logic k5, input logic [4:0] t);
        if (!k5)           return E_MODE;
        else if (t < 5'd9)  return A_MODE;
        else if (t < 5'd15) return B_MODE;
        else if (t < 5'd21) return C_MODE;
        else                return D_MODE;
    endfunction

    assign tap_last = (tap_q == (mode5_q ? 5'd24 : 5'd8));
    assign row_last = (row_q == RW'(CONF_PE_ROW - 1));
    assign rd_fire  = (state_q == FETCH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = (group_num == 8'd0) ? DONE : FETCH;
            FETCH:    if (tap_last && row_last) state_d = DRAIN;
            DRAIN:    state_d = WAIT_ACK;
            WAIT_ACK: if (pe_wt_ack)
                          state_d = (({1'b0, grp_q} + 9'd1) < {1'b0, gnum_q}) ? FETCH : DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode5_q   <= 1'b0;
            gnum_q    <= '0;
            grp_q     <= '0;
            addr_q    <= '0;
            tap_q     <= '0;
            row_q     <= '0;
            we_q      <= 1'b0;
            commit_q  <= 1'b0;
            row_sel_q <= '0;
            idx_q     <= '0;
            wmode_q   <= '0;
        end else begin
            state_q  <= state_d;
            commit_q <= (state_q == DRAIN);
            // Tags ride one cycle behind the read so they line up with returning data.
            we_q      <= rd_fire;
            row_sel_q <= rd_fire ? (CONF_PE_ROW'(1) << row_q) : '0;
            idx_q     <= rd_fire ? tap_q : '0;
            wmode_q   <= rd_fire ? 3'(tap_mode(mode5_q, tap_q)) : '0;

            case (state_q)
                IDLE: if (start) begin
                    mode5_q <= kernel_mode;
                    gnum_q  <= group_num;
                    addr_q  <= base_addr;
                    tap_q   <= '0;
                    row_q   <= '0;
                    grp_q   <= '0;
                end
                FETCH: begin
                    addr_q <= (addr_q == AW'(CONF_WT_BUF_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    if (tap_last) begin
                        tap_q <= '0;
                        row_q <= row_last ? '0 : row_q + RW'(1);
                    end else begin
                        tap_q <= tap_q + 5'd1;
                    end
                end
                WAIT_ACK: if (pe_wt_ack) grp_q <= grp_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign busy         = (state_q == FETCH) || (state_q == DRAIN) || (state_q == WAIT_ACK);
    assign done         = (state_q == DONE);
    assign wt_rd_en     = rd_fire;
    assign wt_rd_addr   = rd_fire ? addr_q : '0;
    assign pe_wt_we     = we_q;
    assign pe_row_sel   = row_sel_q;
    assign pe_wt_idx    = idx_q;
    assign pe_wt_mode   = wmode_q;
    assign pe_wt_data   = we_q ? wt_rd_data : '0;
    assign pe_wt_commit = commit_q;

endmodule
